avm_uart_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter that shares the single RS232/UART Avalon slave (RX/TX/STATUS registers) between master 0 (RSA wrapper) and master 1 (debug/host-status master).
- Sits between the masters and the UART slave port.
- Round-robin grant, one transfer per grant, optional lock for back-to-back exclusive access (e.g. a STATUS poll followed by an RX/TX access).

---
 rtl/avm_uart_arbiter.sv | 110 +++++++++++
 tb/tb_avm_uart_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avm_uart_arbiter.sv
// avm_uart_arbiter: round-robin, lockable two-master Avalon-MM arbiter for the shared UART slave.
// Define ARB_WATCHDOG_EN to abort slave transfers still stalled after WDT_CYCLES cycles.
module avm_uart_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int WDT_CYCLES = 1023
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    output logic [1:0]        arb_grant,
    output logic              arb_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state;
    logic              owner, last_grant, lock_on, lock_id, timeout;
    logic              req0, req1, gnt_sel, gnt_any, capture;
    logic [DATA_W-1:0] rdata;
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        gnt_sel = lock_on ? lock_id : ((req0 & req1) ? ~last_grant : req1);
        gnt_any = gnt_sel ? req1 : req0;
        capture = s_read | timeout;
        rdata   = timeout ? DATA_W'(32'hDEADBEEF) : s_readdata;
    end
`ifdef ARB_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;
    always_ff @(posedge avm_clk or posedge avm_rst)
        if (avm_rst) wdt_cnt <= '0;
        else wdt_cnt <= (state == BUSY) ? wdt_cnt + WDT_W'(1) : '0;
    assign timeout = (state == BUSY) && s_waitrequest && (wdt_cnt == WDT_W'(WDT_CYCLES));
`else
    logic unused_wdt;
    assign unused_wdt = WDT_CYCLES != 0;
    assign timeout    = 1'b0;
`endif
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state          <= IDLE;
            s_address      <= '0;
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            s_writedata    <= '0;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            arb_grant      <= 2'b00;
            arb_timeout    <= 1'b0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            lock_on        <= 1'b0;
            lock_id        <= 1'b0;
        end else begin
            arb_timeout <= timeout;
            case (state)
                IDLE: if (gnt_any) begin
                    owner       <= gnt_sel;
                    arb_grant   <= gnt_sel ? 2'b10 : 2'b01;
                    s_address   <= gnt_sel ? m1_address : m0_address;
                    s_writedata <= gnt_sel ? m1_writedata : m0_writedata;
                    s_read      <= gnt_sel ? m1_read : m0_read;
                    s_write     <= gnt_sel ? (m1_write & ~m1_read) : (m0_write & ~m0_read);
                    state       <= BUSY;
                end
                BUSY: if (!s_waitrequest || timeout) begin
                    if (capture && !owner) m0_readdata <= rdata;
                    if (capture && owner) m1_readdata <= rdata;
                    m0_waitrequest <= owner;
                    m1_waitrequest <= ~owner;
                    s_read         <= 1'b0;
                    s_write        <= 1'b0;
                    state          <= DONE;
                end
                DONE: begin
                    // an aborted transfer never keeps the lock, whatever the master asks
                    m0_waitrequest <= 1'b1;
                    m1_waitrequest <= 1'b1;
                    arb_grant      <= 2'b00;
                    last_grant     <= owner;
                    lock_on        <= ~arb_timeout & (owner ? m1_lock : m0_lock);
                    lock_id        <= owner;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avm_uart_arbiter.sv
// tb_avm_uart_arbiter: directed bench for avm_uart_arbiter with per-master scoreboards.
// Watchdog checks run only when ARB_WATCHDOG_EN is defined.
module tb_avm_uart_arbiter;
    typedef struct packed {logic rd; logic wr; logic lock; logic [4:0] addr; logic [31:0] data;} cmd_t;
    typedef struct packed {logic rd; logic to; logic [31:0] data;} exp_t;

    logic        avm_clk = 1'b0, avm_rst = 1'b1;
    logic [4:0]  m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m0_lock, m0_waitrequest;
    logic        m1_read, m1_write, m1_lock, m1_waitrequest;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest, arb_timeout;
    logic [31:0] s_writedata, s_readdata;
    logic [1:0]  arb_grant;

    int   n_checks = 0, n_fail = 0;
    int   slv_wait = 0, slv_cnt = 0;
    cmd_t q0[$], q1[$];
    exp_t exp0_q[$], exp1_q[$];
    bit   done_log[$];

    avm_uart_arbiter #(.ADDR_W(5), .DATA_W(32), .WDT_CYCLES(8)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .arb_grant(arb_grant), .arb_timeout(arb_timeout)
    );

    always #5 avm_clk = ~avm_clk;

    // slave model: stalls slv_wait cycles per access, read data is address << 4
    assign s_readdata    = 32'(s_address) << 4;
    assign s_waitrequest = slv_cnt < slv_wait;
    always @(posedge avm_clk) slv_cnt <= (s_read | s_write) ? slv_cnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t rd_cmd(input logic [4:0] a, input logic l);
        return '{rd: 1'b1, wr: 1'b0, lock: l, addr: a, data: 32'h0};
    endfunction

    function automatic exp_t rd_exp(input logic [4:0] a);
        return '{rd: 1'b1, to: 1'b0, data: {23'h0, a, 4'h0}};
    endfunction

    task automatic wait_log(input int n);
        for (int k = 0; k < 300 && done_log.size() < n; k++) @(negedge avm_clk);
        check("wait_completions", 32'(done_log.size() >= n), 32'd1);
    endtask

    task automatic complete(input bit m);
        exp_t e;
        check(m ? "m1_expected" : "m0_expected", 32'(m ? exp1_q.size() != 0 : exp0_q.size() != 0), 32'd1);
        if (m ? exp1_q.size() == 0 : exp0_q.size() == 0) return;
        if (m) e = exp1_q.pop_front();
        else e = exp0_q.pop_front();
        if (e.rd || e.to) check(m ? "m1_readdata" : "m0_readdata", m ? m1_readdata : m0_readdata, e.data);
        check("grant_at_done", 32'(arb_grant), m ? 32'd2 : 32'd1);
        check("timeout_at_done", 32'(arb_timeout), 32'(e.to));
        done_log.push_back(m);
    endtask

    always @(negedge avm_clk) if (!avm_rst && !(m0_waitrequest && m1_waitrequest)) begin
        check("single_completion", 32'(m0_waitrequest | m1_waitrequest), 32'd1);
        if (!m0_waitrequest) complete(1'b0);
        if (!m1_waitrequest) complete(1'b1);
    end

    initial begin : drv0
        cmd_t c;
        {m0_address, m0_read, m0_write, m0_writedata, m0_lock} = '0;
        forever begin
            @(posedge avm_clk); #1;
            if (q0.size() != 0) begin
                c = q0.pop_front();
                {m0_read, m0_write, m0_lock, m0_address, m0_writedata} = c;
                do @(negedge avm_clk); while (m0_waitrequest && !avm_rst);
            end else begin
                m0_read  = 1'b0;
                m0_write = 1'b0;
            end
        end
    end

    initial begin : drv1
        cmd_t c;
        {m1_address, m1_read, m1_write, m1_writedata, m1_lock} = '0;
        forever begin
            @(posedge avm_clk); #1;
            if (q1.size() != 0) begin
                c = q1.pop_front();
                {m1_read, m1_write, m1_lock, m1_address, m1_writedata} = c;
                do @(negedge avm_clk); while (m1_waitrequest && !avm_rst);
            end else begin
                m1_read  = 1'b0;
                m1_write = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n_wr, n_done, n_to;
        bit prev_acc;
        repeat (2) @(negedge avm_clk);
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_s_write", 32'(s_write), 32'd0);
        check("rst_s_address", 32'(s_address), 32'd0);
        check("rst_s_writedata", s_writedata, 32'd0);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_m0_rdata", m0_readdata, 32'd0);
        check("rst_m1_rdata", m1_readdata, 32'd0);
        check("rst_grant", 32'(arb_grant), 32'd0);
        check("rst_timeout", 32'(arb_timeout), 32'd0);
        avm_rst = 1'b0;

        // single read, zero wait states: cycle-exact latency
        @(posedge avm_clk);
        q0.push_back(rd_cmd(5'd8, 1'b0));
        exp0_q.push_back(rd_exp(5'd8));
        @(negedge avm_clk);
        check("t_grant", 32'(arb_grant), 32'd0);
        check("t_s_read", 32'(s_read), 32'd0);
        @(negedge avm_clk);
        check("t1_s_read", 32'(s_read), 32'd1);
        check("t1_s_address", 32'(s_address), 32'd8);
        check("t1_grant", 32'(arb_grant), 32'd1);
        check("t1_m0_wait", 32'(m0_waitrequest), 32'd1);
        @(negedge avm_clk);
        check("t2_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("t2_m0_rdata", m0_readdata, 32'h80);
        check("t2_s_read", 32'(s_read), 32'd0);
        @(negedge avm_clk);
        check("t3_grant", 32'(arb_grant), 32'd0);
        check("t3_m0_wait", 32'(m0_waitrequest), 32'd1);

        // continuous contention: last winner was m0, so m1 goes first
        done_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rd_cmd(5'(i + 1), 1'b0));
            exp0_q.push_back(rd_exp(5'(i + 1)));
            q1.push_back(rd_cmd(5'(i + 16), 1'b0));
            exp1_q.push_back(rd_exp(5'(i + 16)));
        end
        wait_log(8);
        for (int i = 0; i < 8; i++) check("rr_order", 32'(done_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

        // stalled write: 3 wait states keep s_write for 4 cycles
        repeat (3) @(negedge avm_clk);
        slv_wait = 3;
        q1.push_back('{rd: 1'b0, wr: 1'b1, lock: 1'b0, addr: 5'd4, data: 32'h5A});
        exp1_q.push_back('{rd: 1'b0, to: 1'b0, data: 32'h0});
        n_wr = 0; n_done = 0; prev_acc = 1'b0;
        repeat (20) begin
            @(negedge avm_clk);
            if (s_write && s_address == 5'd4 && s_writedata == 32'h5A) n_wr++;
            if (!m1_waitrequest) begin
                n_done++;
                check("wr_done_after_accept", 32'(prev_acc), 32'd1);
            end
            prev_acc = s_write && !s_waitrequest;
        end
        check("wr_hold_cycles", 32'(n_wr), 32'd4);
        check("wr_done_count", 32'(n_done), 32'd1);
        slv_wait = 0;

        // lock: m0 keeps the slave while idle, m1 starves until release
        done_log.delete();
        q0.push_back(rd_cmd(5'd8, 1'b1));
        exp0_q.push_back(rd_exp(5'd8));
        q1.push_back(rd_cmd(5'd2, 1'b0));
        exp1_q.push_back(rd_exp(5'd2));
        wait_log(1);
        check("lock_first", 32'(done_log[0]), 32'd0);
        repeat (6) begin
            @(negedge avm_clk);
            check("lock_starve_grant", 32'(arb_grant), 32'd0);
        end
        q0.push_back(rd_cmd(5'd3, 1'b0));
        exp0_q.push_back(rd_exp(5'd3));
        wait_log(3);
        check("lock_second", 32'(done_log[1]), 32'd0);
        check("lock_release", 32'(done_log[2]), 32'd1);

        // m0 wins once so that only reset can hand the next tie back to m0
        done_log.delete();
        q0.push_back('{rd: 1'b0, wr: 1'b1, lock: 1'b0, addr: 5'd7, data: 32'h1});
        exp0_q.push_back('{rd: 1'b0, to: 1'b0, data: 32'h0});
        wait_log(1);
        slv_wait = 5;
        q0.push_back(rd_cmd(5'd1, 1'b0));
        for (int k = 0; k < 10 && !s_read; k++) @(negedge avm_clk);
        check("rst_busy_reached", 32'(s_read), 32'd1);
        #2 avm_rst = 1'b1;
        #1;
        check("rst_busy_s_read", 32'(s_read), 32'd0);
        check("rst_busy_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("rst_busy_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("rst_busy_grant", 32'(arb_grant), 32'd0);
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        slv_wait = 0;
        done_log.delete();
        q0.push_back(rd_cmd(5'd5, 1'b0));
        exp0_q.push_back(rd_exp(5'd5));
        q1.push_back(rd_cmd(5'd6, 1'b0));
        exp1_q.push_back(rd_exp(5'd6));
        wait_log(2);
        check("post_rst_tie_first", 32'(done_log[0]), 32'd0);
        check("post_rst_tie_second", 32'(done_log[1]), 32'd1);

`ifdef ARB_WATCHDOG_EN
        // slave never answers: abort after the counter reaches 8
        repeat (2) @(negedge avm_clk);
        slv_wait = 1000;
        q1.push_back(rd_cmd(5'd9, 1'b0));
        exp1_q.push_back('{rd: 1'b1, to: 1'b1, data: 32'hDEADBEEF});
        n_wr = 0; n_to = 0;
        repeat (30) begin
            @(negedge avm_clk);
            if (s_read) n_wr++;
            if (arb_timeout) n_to++;
        end
        check("wdt_busy_cycles", 32'(n_wr), 32'd9);
        check("wdt_pulses", 32'(n_to), 32'd1);
        slv_wait = 0;
`endif
        repeat (3) @(negedge avm_clk);
        check("exp0_drained", 32'(exp0_q.size()), 32'd0);
        check("exp1_drained", 32'(exp1_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
